// File: rtl/vgacon_pkg.sv
// rtl/vgacon_pkg.sv - shared text-console geometry, control codes and tty state encoding
package vgacon_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 10;
    localparam int N_CHARS  = NUM_ROWS * NUM_COLS;

    localparam logic [8:0] BLANK = 9'h020;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        COPY  = 2'd2,
        FILL  = 2'd3
    } tty_state_t;

endpackage

// File: rtl/vgacon_tty_ctrl.sv
// rtl/vgacon_tty_ctrl.sv - byte-stream terminal writer for the VGA text buffer
// VGACON_TTY_SCROLL_EN: last-row advance scrolls; otherwise wraps to row 0 and erases it.
module vgacon_tty_ctrl
    import vgacon_pkg::*;
#(
    parameter int NUM_ROWS = vgacon_pkg::NUM_ROWS,
    parameter int NUM_COLS = vgacon_pkg::NUM_COLS,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    input  logic [1:0]        ch_color,
    output logic              ch_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [8:0]        buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [8:0]        buf_rdata,
    output logic [1:0]        cur_row,
    output logic [3:0]        cur_col,
    output logic              busy
);

    localparam int N = NUM_ROWS * NUM_COLS;
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] LROW_A   = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [1:0]        ROW_LAST = 2'(NUM_ROWS - 1);
    localparam logic [3:0]        COL_LAST = 4'(NUM_COLS - 1);
`ifdef VGACON_TTY_SCROLL_EN
    localparam logic [ADDR_W-1:0] FILL_END = LAST_A;
`else
    localparam logic [ADDR_W-1:0] FILL_END = COLS_A - ONE_A;
`endif

    tty_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        wdata_q, wdata_d;
    logic [8:0]        cap_q, cap_d;
    logic [ADDR_W-1:0] row_a, row_base, cur_addr, raddr;
    logic              adv;
    logic              rdata_unused;

    assign row_a    = ADDR_W'(row_q);
    assign row_base = (NUM_COLS == 10) ? (row_a << 3) + (row_a << 1) : row_a * COLS_A;
    assign cur_addr = row_base + ADDR_W'(col_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        raddr   = '0;
        adv     = 1'b0;
        case (state_q)
            CLEAR: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = BLANK;
                if (cnt_q == LAST_A) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_A;
                end
            end
            IDLE: begin
                if (ch_valid) begin
                    if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
                        we_d    = 1'b1;
                        addr_d  = cur_addr;
                        wdata_d = {ch_color, ch_data[6:0]};
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            adv   = 1'b1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else begin
                        case (ch_data)
                            CC_LF: begin
                                col_d = '0;
                                adv   = 1'b1;
                            end
                            CC_CR: col_d = '0;
                            CC_BS: begin
                                if (col_q != 4'd0) begin
                                    col_d   = col_q - 4'd1;
                                    we_d    = 1'b1;
                                    addr_d  = cur_addr - ONE_A;
                                    wdata_d = BLANK;
                                end
                            end
                            CC_FF: begin
                                state_d = CLEAR;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                if (adv) begin
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + 2'd1;
                    end else begin
`ifdef VGACON_TTY_SCROLL_EN
                        state_d = COPY;
`else
                        row_d   = '0;
                        state_d = FILL;
`endif
                        cnt_d = '0;
                    end
                end
            end
`ifdef VGACON_TTY_SCROLL_EN
            // Read at cnt, write the captured cell one cycle later; cnt==LROW_A only drains.
            COPY: begin
                if (cnt_q != LROW_A) begin
                    raddr = cnt_q + COLS_A;
                    cap_d = buf_rdata;
                end
                if (cnt_q != '0) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q - ONE_A;
                    wdata_d = cap_q;
                end
                if (cnt_q == LROW_A) begin
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + ONE_A;
                end
            end
`endif
            FILL: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = BLANK;
                if (cnt_q == FILL_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_A;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
        end
    end

    assign rdata_unused = ^buf_rdata;
    assign ch_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign buf_we       = we_q;
    assign buf_addr     = addr_q;
    assign buf_wdata    = wdata_q;
    assign buf_raddr    = raddr;
    assign cur_row      = row_q;
    assign cur_col      = col_q;

endmodule

// File: tb/tb_vgacon_tty_ctrl.sv
// tb/tb_vgacon_tty_ctrl.sv - scoreboard bench for vgacon_tty_ctrl with a behavioural text buffer
module tb_vgacon_tty_ctrl;

    localparam logic [8:0] BL = 9'h020;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ch_valid = 1'b0;
    logic [7:0] ch_data = 8'h00;
    logic [1:0] ch_color = 2'd0;
    logic       ch_ready, buf_we, busy;
    logic [4:0] buf_addr, buf_raddr;
    logic [8:0] buf_wdata, buf_rdata;
    logic [1:0] cur_row;
    logic [3:0] cur_col;

    logic [8:0]  mem [0:31];
    logic [8:0]  ref_mem [0:29];
    logic [13:0] exp_q [$];
    logic [1:0]  m_row = 2'd0;
    logic [3:0]  m_col = 4'd0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vgacon_tty_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_color(ch_color), .ch_ready(ch_ready), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata), .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always @(posedge clk) if (buf_we) mem[buf_addr] <= buf_wdata;
    assign buf_rdata = mem[buf_raddr];

    always @(negedge clk) begin
        if (rst_n && buf_we) begin
            logic [13:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%0d data=%h required=none", buf_addr, buf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({buf_addr, buf_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL buf_write got addr=%0d data=%h required addr=%0d data=%h",
                             buf_addr, buf_wdata, e[13:9], e[8:0]);
                end
            end
        end
    end

    task automatic push_wr(input int a, input logic [8:0] v);
        exp_q.push_back({5'(a), v});
        ref_mem[a] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 30; i++) push_wr(i, BL);
        m_row = 2'd0;
        m_col = 4'd0;
    endtask

    task automatic model_adv();
        if (m_row < 2'd2) begin
            m_row = m_row + 2'd1;
        end else begin
`ifdef VGACON_TTY_SCROLL_EN
            for (int i = 0; i < 20; i++) push_wr(i, ref_mem[i + 10]);
            for (int i = 20; i < 30; i++) push_wr(i, BL);
`else
            m_row = 2'd0;
            for (int i = 0; i < 10; i++) push_wr(i, BL);
`endif
        end
    endtask

    task automatic model_byte(input logic [7:0] d, input logic [1:0] c);
        int a = int'(m_row) * 10 + int'(m_col);
        if (d >= 8'h20 && d <= 8'h7E) begin
            push_wr(a, {c, d[6:0]});
            if (m_col < 4'd9) m_col = m_col + 4'd1;
            else begin m_col = 4'd0; model_adv(); end
        end else if (d == 8'h0A) begin
            m_col = 4'd0;
            model_adv();
        end else if (d == 8'h0D) begin
            m_col = 4'd0;
        end else if (d == 8'h08) begin
            if (m_col > 4'd0) begin
                m_col = m_col - 4'd1;
                push_wr(a - 1, BL);
            end
        end else if (d == 8'h0C) begin
            model_clear();
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] c);
        int n = 0;
        @(negedge clk);
        while (!ch_ready && n < 200) begin @(negedge clk); n++; end
        vectors++;
        if (!ch_ready) begin
            miscompares++;
            $display("FAIL ready_timeout byte=%h ready=%b required=1", d, ch_ready);
        end
        model_byte(d, c);
        ch_valid = 1'b1; ch_data = d; ch_color = c;
        @(posedge clk); #1;
        ch_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        ch_valid = 1'b1; ch_data = 8'h51; ch_color = 2'd0;
        #2 rst_n = 1'b0;
        #20;
        vectors++;
        if ({buf_we, buf_addr, buf_wdata, busy, ch_ready, cur_row, cur_col} !== {1'b0, 5'd0, 9'd0, 1'b1, 1'b0, 2'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_values we=%b addr=%0d wdata=%h busy=%b ready=%b cur=%0d,%0d required 0,0,000,1,0,0,0",
                     buf_we, buf_addr, buf_wdata, busy, ch_ready, cur_row, cur_col);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!ch_ready && n < 200) begin n++; @(negedge clk); end
        vectors++;
        if (n != 30) begin miscompares++; $display("FAIL clear_ready_low got=%0d required=30", n); end
        vectors++;
        if ({cur_row, cur_col} !== 6'd0) begin
            miscompares++;
            $display("FAIL clear_cursor got=%0d,%0d required=0,0", cur_row, cur_col);
        end
        model_byte(8'h51, 2'd0);
        @(posedge clk); #1;
        ch_valid = 1'b0;
        drain();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL reset_drain pending=%0d required=0", exp_q.size()); end
        vectors++;
        if ({cur_row, cur_col} !== {m_row, m_col}) begin
            miscompares++;
            $display("FAIL first_byte_cursor got=%0d,%0d required=%0d,%0d", cur_row, cur_col, m_row, m_col);
        end
    endtask

    task automatic test_print();
        send(8'h0C, 2'd0);
        send(8'h41, 2'd1);
        send(8'h42, 2'd3);
        drain();
        vectors++;
        if (mem[0] !== 9'h0C1 || mem[1] !== 9'h1C2) begin
            miscompares++;
            $display("FAIL print_cells got=%h,%h required=0c1,1c2", mem[0], mem[1]);
        end
        vectors++;
        if ({cur_row, cur_col} !== {2'd0, 4'd2}) begin
            miscompares++;
            $display("FAIL print_cursor got=%0d,%0d required=0,2", cur_row, cur_col);
        end
    endtask

    task automatic test_crlf();
        logic [7:0] seq [6] = '{8'h0C, 8'h48, 8'h49, 8'h0D, 8'h0A, 8'h58};
        foreach (seq[i]) send(seq[i], 2'd2);
        drain();
        vectors++;
        if (mem[10] !== 9'h158 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL crlf_cell got=%h pending=%0d required=158 pending=0", mem[10], exp_q.size());
        end
        vectors++;
        if ({cur_row, cur_col} !== {2'd1, 4'd1}) begin
            miscompares++;
            $display("FAIL crlf_cursor got=%0d,%0d required=1,1", cur_row, cur_col);
        end
    endtask

    task automatic test_wrap_line();
        send(8'h0C, 2'd0);
        for (int i = 0; i < 11; i++) send(8'h5A, 2'd0);
        drain();
        vectors++;
        if ({cur_row, cur_col} !== {2'd1, 4'd1} || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_line cursor=%0d,%0d pending=%0d required=1,1 pending=0", cur_row, cur_col, exp_q.size());
        end
    endtask

    task automatic test_scroll();
        int n, errs;
        send(8'h0C, 2'd0);
        for (int i = 0; i < 29; i++) send(8'(8'h21 + i), 2'(i));
        send(8'h0A, 2'd0);
        n = 0;
        @(negedge clk);
        while (!ch_ready && n < 200) begin n++; @(negedge clk); end
        vectors++;
`ifdef VGACON_TTY_SCROLL_EN
        if (n != 31) begin miscompares++; $display("FAIL scroll_ready_low got=%0d required=31", n); end
`else
        if (n != 10) begin miscompares++; $display("FAIL wrap_ready_low got=%0d required=10", n); end
`endif
        drain();
        errs = 0;
        for (int i = 0; i < 30; i++) if (mem[i] !== ref_mem[i]) errs++;
        vectors++;
        if (errs != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scroll_buffer wrong_cells=%0d pending=%0d required=0,0", errs, exp_q.size());
        end
        vectors++;
        if ({cur_row, cur_col} !== {m_row, 4'd0}) begin
            miscompares++;
            $display("FAIL scroll_cursor got=%0d,%0d required=%0d,0", cur_row, cur_col, m_row);
        end
    endtask

    task automatic test_edit_codes();
        logic [1:0] r0;
        r0 = m_row;
        send(8'h08, 2'd0);
        drain();
        vectors++;
        if ({cur_row, cur_col} !== {r0, 4'd0}) begin
            miscompares++;
            $display("FAIL bs_col0_cursor got=%0d,%0d required=%0d,0", cur_row, cur_col, r0);
        end
        send(8'h6B, 2'd2);
        send(8'h08, 2'd0);
        send(8'h7F, 2'd1);
        send(8'h85, 2'd1);
        send(8'h01, 2'd1);
        drain();
        vectors++;
        if ({cur_row, cur_col} !== {r0, 4'd0} || mem[int'(r0) * 10] !== BL) begin
            miscompares++;
            $display("FAIL bs_ignore cursor=%0d,%0d cell=%h required=%0d,0 cell=020",
                     cur_row, cur_col, mem[int'(r0) * 10], r0);
        end
        send(8'h6D, 2'd0);
        send(8'h6E, 2'd0);
        send(8'h0C, 2'd0);
        drain();
        vectors++;
        if ({cur_row, cur_col} !== 6'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ff_cursor got=%0d,%0d pending=%0d required=0,0 pending=0", cur_row, cur_col, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_scroll();
        send(8'h0C, 2'd0);
        send(8'h0A, 2'd0);
        send(8'h0A, 2'd0);
        send(8'h0A, 2'd0);
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_scroll_busy got=%b required=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({buf_we, buf_addr, buf_wdata, busy, ch_ready, cur_row, cur_col} !== {1'b0, 5'd0, 9'd0, 1'b1, 1'b0, 2'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL async_reset we=%b addr=%0d wdata=%h busy=%b ready=%b cur=%0d,%0d required 0,0,000,1,0,0,0",
                     buf_we, buf_addr, buf_wdata, busy, ch_ready, cur_row, cur_col);
        end
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        vectors++;
        if (exp_q.size() != 0 || ch_ready !== 1'b1 || {cur_row, cur_col} !== 6'd0) begin
            miscompares++;
            $display("FAIL reclear pending=%0d ready=%b cur=%0d,%0d required 0,1,0,0",
                     exp_q.size(), ch_ready, cur_row, cur_col);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 9'h000;
        for (int i = 0; i < 30; i++) ref_mem[i] = 9'h000;
        test_reset();
        test_print();
        test_crlf();
        test_wrap_line();
        test_scroll();
        test_edit_codes();
        test_reset_mid_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit reached required=finish");
        $fatal(1, "timeout");
    end

endmodule
